mult_div_ctrl: RTL and testbench

Sequential multiply/divide unit and controller feeding the HI/LO registers of the multicycle CPU. It accepts a signed mult or div request from the main control FSM and iterates one bit per cycle. It produces HI/LO result buses and drives the HI/LO mux selectors and write enables, which the main FSM no longer controls. It also flags divide-by-zero so the main FSM can take the exception path through EPC.

---
 rtl/mult_div_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mult_div_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_ctrl.sv
// Sequential signed multiply/divide unit feeding HI/LO. It uses radix-2 Booth for
// multiply and restoring division on magnitudes for divide, producing one bit per cycle.
module mult_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] mult_hi,
    output logic [WIDTH-1:0] mult_lo,
    output logic [WIDTH-1:0] div_hi,
    output logic [WIDTH-1:0] div_lo,
    output logic             hi_selector,
    output logic             lo_selector,
    output logic             hi_write,
    output logic             lo_write
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_DONE,
        S_DIVZERO
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic             last_step;

    // Booth datapath: a WIDTH+1 bit accumulator keeps acc - (-2^(WIDTH-1)) from overflowing
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH:0]   acc, m_ext, booth_sum, acc_next;
    logic [WIDTH-1:0] mq, mq_next;
    logic             q_m1;

    // Restoring divider datapath on magnitudes
    logic [WIDTH-1:0] dvs, quo, rem, quo_next, rem_next, quo_fix, rem_fix;
    logic [WIDTH:0]   shifted, diff;
    logic             q_neg, r_neg;

    assign last_step = (count == CW'(WIDTH - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        div_zero   = 1'b0;
        hi_write   = 1'b0;
        lo_write   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_mult)                 state_next = S_MULT;
                else if (start_div && b == '0)  state_next = S_DIVZERO;
                else if (start_div)             state_next = S_DIV;
            end
            S_MULT: begin
                busy = 1'b1;
                if (last_step) state_next = S_DONE;
            end
            S_DIV: begin
                busy = 1'b1;
                if (last_step) state_next = S_DONE;
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                hi_write   = 1'b1;
                lo_write   = 1'b1;
                state_next = S_IDLE;
            end
            S_DIVZERO: begin
                busy       = 1'b1;
                div_zero   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign m_ext = {m_reg[WIDTH-1], m_reg};

    always_comb begin
        booth_sum = acc;
        case ({mq[0], q_m1})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
        acc_next = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        mq_next  = {booth_sum[0], mq[WIDTH-1:1]};
    end

    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {1'b0, dvs};
        rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
        quo_fix  = q_neg ? -quo_next : quo_next;
        rem_fix  = r_neg ? -rem_next : rem_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            m_reg       <= '0;
            acc         <= '0;
            mq          <= '0;
            q_m1        <= 1'b0;
            dvs         <= '0;
            quo         <= '0;
            rem         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            mult_hi     <= '0;
            mult_lo     <= '0;
            div_hi      <= '0;
            div_lo      <= '0;
            hi_selector <= 1'b0;
            lo_selector <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    count <= '0;
                    if (start_mult) begin
                        m_reg       <= a;
                        mq          <= b;
                        acc         <= '0;
                        q_m1        <= 1'b0;
                        hi_selector <= 1'b0;
                        lo_selector <= 1'b0;
                    end else if (start_div && b != '0) begin
                        dvs         <= b[WIDTH-1] ? -b : b;
                        quo         <= a[WIDTH-1] ? -a : a;
                        rem         <= '0;
                        q_neg       <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_neg       <= a[WIDTH-1];
                        hi_selector <= 1'b1;
                        lo_selector <= 1'b1;
                    end
                end
                S_MULT: begin
                    acc   <= acc_next;
                    mq    <= mq_next;
                    q_m1  <= mq[0];
                    count <= count + CW'(1);
                    if (last_step) begin
                        mult_hi <= acc_next[WIDTH-1:0];
                        mult_lo <= mq_next;
                    end
                end
                S_DIV: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + CW'(1);
                    if (last_step) begin
                        div_hi <= rem_fix;
                        div_lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Randomized scoreboard bench for mult_div_ctrl: the driver pushes expected results
// from an arithmetic model, and a negedge monitor pops them on done/div_zero.
module tb_mult_div_ctrl;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start_mult, start_div;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] mult_hi, mult_lo, div_hi, div_lo;
    logic         hi_selector, lo_selector, hi_write, lo_write;

    mult_div_ctrl #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset),
        .start_mult(start_mult), .start_div(start_div),
        .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero),
        .mult_hi(mult_hi), .mult_lo(mult_lo),
        .div_hi(div_hi), .div_lo(div_lo),
        .hi_selector(hi_selector), .lo_selector(lo_selector),
        .hi_write(hi_write), .lo_write(lo_write)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit           zero;
        logic [W-1:0] mh, ml, dh, dl;
        logic         sel;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model view of what the HI/LO buses and selectors should currently hold
    logic [W-1:0] m_mh, m_ml, m_dh, m_dl;
    logic         m_sel;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset === 1'b1) begin
            check("write_eq_done", {62'd0, hi_write, lo_write}, {62'd0, done, done});
            if (done || div_zero) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: done=%b div_zero=%b with empty scoreboard", done, div_zero);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("div_zero", div_zero, e.zero);
                    check("done", done, !e.zero);
                    check("mult_hi", mult_hi, e.mh);
                    check("mult_lo", mult_lo, e.ml);
                    check("div_hi", div_hi, e.dh);
                    check("div_lo", div_lo, e.dl);
                    check("selectors", {hi_selector, lo_selector}, {e.sel, e.sel});
                end
            end
        end
    end

    // Issue one operation; poke_at pulses start_mult mid-run, reset_at aborts with reset.
    task automatic run_op(input bit do_mult, input bit do_div, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input int poke_at, input int reset_at);
        bit     is_div, zero;
        int     last;
        longint sa, sbv, prod, q, r;
        logic [63:0] p;
        exp_t   e;
        is_div = !do_mult && do_div;
        zero   = is_div && (bv == '0);
        @(negedge clock);
        start_mult = do_mult;
        start_div  = do_div;
        a = av;
        b = bv;
        if (reset_at == 0) begin
            sa  = $signed(av);
            sbv = $signed(bv);
            if (!is_div) begin
                prod = sa * sbv;
                p    = prod;
                m_mh = p[63:32];
                m_ml = p[31:0];
                m_sel = 1'b0;
            end else if (!zero) begin
                q = sa / sbv;
                r = sa % sbv;
                m_dl = q[31:0];
                m_dh = r[31:0];
                m_sel = 1'b1;
            end
            e.zero = zero;
            e.mh = m_mh; e.ml = m_ml; e.dh = m_dh; e.dl = m_dl; e.sel = m_sel;
            sb.push_back(e);
        end
        last = zero ? 1 : W + 1;
        for (int n = 1; n <= last + 1; n++) begin
            @(negedge clock);
            if (n == 1) begin
                start_mult = 1'b0;
                start_div  = 1'b0;
                a = $urandom;
                b = $urandom;
            end
            if (n == reset_at) begin
                reset = 1'b0;
                #1;
                check("rst_busy", busy, 1'b0);
                check("rst_flags", {done, div_zero, hi_write, lo_write}, 4'd0);
                check("rst_mult", {mult_hi, mult_lo}, 64'd0);
                check("rst_div", {div_hi, div_lo}, 64'd0);
                check("rst_sel", {hi_selector, lo_selector}, 2'd0);
                @(negedge clock);
                reset = 1'b1;
                m_mh = '0; m_ml = '0; m_dh = '0; m_dl = '0; m_sel = 1'b0;
                return;
            end
            check("busy_timing", busy, n <= last);
            check("done_timing", done, (n == last) && !zero);
            if (n == poke_at) begin
                start_mult = 1'b1;
                a = $urandom;
                b = $urandom;
            end
            if (n == poke_at + 1) start_mult = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a = '0;
        b = '0;
        m_mh = '0; m_ml = '0; m_dh = '0; m_dl = '0; m_sel = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_busy", busy, 1'b0);
        check("reset_outs", {done, div_zero, hi_write, lo_write, hi_selector, lo_selector}, 6'd0);
        check("reset_bus", {mult_hi, mult_lo}, 64'd0);
        reset = 1'b1;

        run_op(1, 0, 32'd7, 32'hFFFF_FFFD, 0, 0);
        check("tp_mul_hi", mult_hi, 32'hFFFF_FFFF);
        check("tp_mul_lo", mult_lo, 32'hFFFF_FFEB);
        check("tp_mul_sel", {hi_selector, lo_selector}, 2'b00);

        run_op(1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0);
        check("tp_big_hi", mult_hi, 32'h3FFF_FFFF);
        check("tp_big_lo", mult_lo, 32'h0000_0001);

        run_op(0, 1, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("tp_div_lo", div_lo, 32'hFFFF_FFFD);
        check("tp_div_hi", div_hi, 32'hFFFF_FFFF);
        check("tp_div_sel", {hi_selector, lo_selector}, 2'b11);

        run_op(0, 1, 32'd5, 32'd0, 0, 0);
        check("tp_dz_hold", {div_hi, div_lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        check("tp_dz_sel", {hi_selector, lo_selector}, 2'b11);

        run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("tp_ovf_lo", div_lo, 32'h8000_0000);
        check("tp_ovf_hi", div_hi, 32'd0);

        run_op(0, 1, 32'd100, 32'd7, 10, 0);
        check("tp_poke_q", {div_hi, div_lo}, {32'd2, 32'd14});

        run_op(1, 1, 32'd9, 32'd6, 0, 0);
        check("tp_both", {mult_lo, 31'd0, hi_selector}, {32'd54, 32'd0});

        run_op(1, 0, 32'd3, 32'd4, 0, 15);
        run_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check("tp_after_rst", {mult_hi, mult_lo}, 64'd1);

        for (int i = 0; i < 25; i++) begin
            int          kind;
            logic [W-1:0] ra, rb;
            kind = $urandom_range(0, 4);
            ra   = $urandom;
            rb   = $urandom;
            if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 5) - 2;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            case (kind)
                0, 1:    run_op(1, 0, ra, rb, 0, 0);
                2:       run_op(0, 1, ra, rb, 0, 0);
                3:       run_op(1, 1, ra, rb, 0, 0);
                default: run_op(0, 1, ra, (rb == 0) ? 32'd0 : 32'hFFFF_FFFF, 0, 0);
            endcase
        end

        repeat (5) @(negedge clock);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
